// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg
// Shared definitions for the SPI command decoder: command byte codes,
// the decoder state encoding and a saturating-increment helper for the
// error counter.
package spi_cmd_pkg;

    localparam logic [7:0] CMD_NOP    = 8'h00;
    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_BRIGHT = 8'h02;
    localparam logic [7:0] CMD_SWAP   = 8'h03;

    localparam logic [7:0] ERR_MAX    = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR_HI = 3'd1,
        ST_ADDR_LO = 3'd2,
        ST_DATA    = 3'd3,
        ST_BRIGHT  = 3'd4,
        ST_DISCARD = 3'd5
    } state_t;

    // 8-bit increment that sticks at ERR_MAX instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == ERR_MAX) begin
            result = ERR_MAX;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// One-bit two-flop synchronizer for bringing an asynchronous pin into the
// clk domain. Both stages take RST_VAL during reset, so the output shows a
// known level until the real pin value has passed through.
// Ports:
//   clk  - destination clock
//   rst  - synchronous reset, active-low
//   d    - asynchronous input
//   q    - synchronized output (two clk cycles of latency)
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder
// Decodes the byte stream from the SPI slave into framebuffer writes, a
// brightness register and a buffer-swap pulse. One command per frame; a
// frame is the time slave-select is at its active level.
// Ports:
//   clk        - system clock
//   rst        - synchronous reset, active-low
//   ss         - raw slave-select pin (asynchronous)
//   in_data    - received byte
//   in_valid   - one-cycle strobe qualifying in_data
//   wr_en      - framebuffer write strobe (one cycle per data byte)
//   wr_addr    - framebuffer write address
//   wr_data    - framebuffer write data
//   brightness - display brightness register
//   swap       - one-cycle front/back buffer swap request
//   err_count  - saturating count of unknown command bytes
// All outputs are registered and react one clk after the triggering byte.
// ADDR_WIDTH is expected to be between 8 and 16.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter logic       ss_active  = 1'b1,
    parameter int         ADDR_WIDTH = 10,
    parameter logic [7:0] BRIGHT_RST = 8'h80
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ss,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic [7:0]            brightness,
    output logic                  swap,
    output logic [7:0]            err_count
);

    logic                  ss_s;
    logic                  frame_active_s;

    // sync_ok_r fills with ones after reset; once bit 1 is set, ss_s carries
    // the real pin level rather than the synchronizer's reset value.
    logic [1:0]            sync_ok_r;
    // armed_r: a genuine inactive period has been seen since reset, so the
    // next active frame starts cleanly. Until then an active frame is one
    // that reset interrupted and is discarded.
    logic                  armed_r;
    logic                  armed_nxt_s;

    state_t                state_r;
    state_t                state_fsm_s;
    state_t                state_nxt_s;

    logic [7:0]            addr_hi_r;
    logic [7:0]            addr_hi_nxt_s;
    logic [ADDR_WIDTH-1:0] ptr_r;
    logic [ADDR_WIDTH-1:0] ptr_nxt_s;

    logic                  wr_en_r;
    logic                  wr_en_nxt_s;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [ADDR_WIDTH-1:0] wr_addr_nxt_s;
    logic [7:0]            wr_data_r;
    logic [7:0]            wr_data_nxt_s;
    logic [7:0]            bright_r;
    logic [7:0]            bright_nxt_s;
    logic                  swap_r;
    logic                  swap_nxt_s;
    logic [7:0]            err_r;
    logic [7:0]            err_nxt_s;

    sync_2ff #(
        .RST_VAL (~ss_active)
    ) u_ss_sync (
        .clk (clk),
        .rst (rst),
        .d   (ss),
        .q   (ss_s)
    );

    assign frame_active_s = (ss_s == ss_active);

    // Track synchronizer validity and whether a clean frame boundary was seen.
    always_comb begin
        armed_nxt_s = armed_r;
        if (sync_ok_r[1] && !frame_active_s) begin
            armed_nxt_s = 1'b1;
        end else begin
            armed_nxt_s = armed_r;
        end
    end

    // Command decode and per-state byte handling; outputs default to hold,
    // strobes default low.
    always_comb begin
        state_fsm_s   = state_r;
        addr_hi_nxt_s = addr_hi_r;
        ptr_nxt_s     = ptr_r;
        wr_en_nxt_s   = 1'b0;
        wr_addr_nxt_s = wr_addr_r;
        wr_data_nxt_s = wr_data_r;
        bright_nxt_s  = bright_r;
        swap_nxt_s    = 1'b0;
        err_nxt_s     = err_r;
        case (state_r)
            ST_IDLE: begin
                if (frame_active_s && !armed_r) begin
                    state_fsm_s = ST_DISCARD;
                end else if (in_valid && frame_active_s) begin
                    case (in_data)
                        CMD_NOP: begin
                            state_fsm_s = ST_DISCARD;
                        end
                        CMD_WRITE: begin
                            state_fsm_s = ST_ADDR_HI;
                        end
                        CMD_BRIGHT: begin
                            state_fsm_s = ST_BRIGHT;
                        end
                        CMD_SWAP: begin
                            swap_nxt_s  = 1'b1;
                            state_fsm_s = ST_DISCARD;
                        end
                        default: begin
                            err_nxt_s   = sat_inc8(err_r);
                            state_fsm_s = ST_DISCARD;
                        end
                    endcase
                end else begin
                    state_fsm_s = ST_IDLE;
                end
            end
            ST_ADDR_HI: begin
                if (in_valid) begin
                    addr_hi_nxt_s = in_data;
                    state_fsm_s   = ST_ADDR_LO;
                end else begin
                    state_fsm_s   = ST_ADDR_HI;
                end
            end
            ST_ADDR_LO: begin
                if (in_valid) begin
                    // Upper address bits beyond ADDR_WIDTH are dropped.
                    ptr_nxt_s   = ADDR_WIDTH'({addr_hi_r, in_data});
                    state_fsm_s = ST_DATA;
                end else begin
                    state_fsm_s = ST_ADDR_LO;
                end
            end
            ST_DATA: begin
                if (in_valid) begin
                    wr_en_nxt_s   = 1'b1;
                    wr_addr_nxt_s = ptr_r;
                    wr_data_nxt_s = in_data;
                    // Natural ADDR_WIDTH overflow gives the wrap to zero.
                    ptr_nxt_s     = ptr_r + ADDR_WIDTH'(1'b1);
                end else begin
                    ptr_nxt_s     = ptr_r;
                end
                state_fsm_s = ST_DATA;
            end
            ST_BRIGHT: begin
                if (in_valid) begin
                    bright_nxt_s = in_data;
                    state_fsm_s  = ST_DISCARD;
                end else begin
                    state_fsm_s  = ST_BRIGHT;
                end
            end
            ST_DISCARD: begin
                state_fsm_s = ST_DISCARD;
            end
            default: begin
                state_fsm_s = ST_IDLE;
            end
        endcase
    end

    // The byte in the last cycle of a frame is still handled above; only the
    // following state is forced back to IDLE.
    assign state_nxt_s = frame_active_s ? state_fsm_s : ST_IDLE;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_ok_r <= 2'b00;
            armed_r   <= 1'b0;
            addr_hi_r <= 8'h00;
            ptr_r     <= '0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= 8'h00;
            bright_r  <= BRIGHT_RST;
            swap_r    <= 1'b0;
            err_r     <= 8'h00;
        end else begin
            sync_ok_r <= {sync_ok_r[0], 1'b1};
            armed_r   <= armed_nxt_s;
            addr_hi_r <= addr_hi_nxt_s;
            ptr_r     <= ptr_nxt_s;
            wr_en_r   <= wr_en_nxt_s;
            wr_addr_r <= wr_addr_nxt_s;
            wr_data_r <= wr_data_nxt_s;
            bright_r  <= bright_nxt_s;
            swap_r    <= swap_nxt_s;
            err_r     <= err_nxt_s;
        end
    end

    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;
    assign brightness = bright_r;
    assign swap       = swap_r;
    assign err_count  = err_r;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder
// Directed frames drive the decoder; each frame's hand-computed expected
// output events (write, swap, brightness change, error count change) are
// queued with the index of the byte that causes them. A monitor turns every
// observed output event into a pop-and-compare, including the cycle.
module tb_spi_cmd_decoder;

    localparam int   AW     = 10;
    localparam logic SS_ON  = 1'b1;
    localparam int   K_WR   = 0;
    localparam int   K_SWAP = 1;
    localparam int   K_BRI  = 2;
    localparam int   K_ERR  = 3;

    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        int            idx;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ss;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [7:0]    brightness;
    logic          swap;
    logic [7:0]    err_count;

    ev_t           exp_q[$];
    int            cyc        = 0;
    int            frame_base = 0;
    int            pass_cnt   = 0;
    int            total_cnt  = 0;
    bit            mon_en     = 1'b0;
    logic [7:0]    prev_bright;
    logic [7:0]    prev_err;
    logic [7:0]    exp_err;
    logic [7:0]    fb[16];

    spi_cmd_decoder #(
        .ss_active  (SS_ON),
        .ADDR_WIDTH (AW),
        .BRIGHT_RST (8'h80)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ss         (ss),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .brightness (brightness),
        .swap       (swap),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_WR:    return "write";
            K_SWAP:  return "swap";
            K_BRI:   return "brightness";
            K_ERR:   return "err_count";
            default: return "other";
        endcase
    endfunction

    task automatic push_ev(input int kind, input logic [AW-1:0] addr,
                           input logic [7:0] data, input int idx);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        e.idx  = idx;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input logic [AW-1:0] addr, input logic [7:0] data);
        ev_t e;
        total_cnt++;
        if (exp_q.size() == 0) begin
            $display("FAIL unexpected_%s: got addr=%0h data=%0h at cycle %0d, none expected",
                     kname(kind), addr, data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.addr === addr && e.data === data &&
                cyc == frame_base + e.idx + 1) begin
                pass_cnt++;
            end else begin
                $display("FAIL %s: got %s addr=%0h data=%0h cycle=%0d, want %s addr=%0h data=%0h cycle=%0d",
                         kname(e.kind), kname(kind), addr, data, cyc,
                         kname(e.kind), e.addr, e.data, frame_base + e.idx + 1);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: every output event after the clock edge must match the queue head.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (wr_en) check_ev(K_WR, wr_addr, wr_data);
                if (swap) check_ev(K_SWAP, '0, 8'h00);
                if (brightness !== prev_bright) check_ev(K_BRI, '0, brightness);
                if (err_count !== prev_err) check_ev(K_ERR, '0, err_count);
                prev_bright = brightness;
                prev_err    = err_count;
            end
        end
    end

    // Frame of n back-to-back bytes from fb[]; with coincide set, SS is
    // dropped so that the synchronized SS goes inactive exactly on the last byte.
    task automatic run_frame(input int n, input bit coincide);
        @(negedge clk);
        ss = SS_ON;
        repeat (2) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) frame_base = cyc;
            in_valid = 1'b1;
            in_data  = fb[i];
            if (coincide && i == n - 3) ss = ~SS_ON;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        ss       = ~SS_ON;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        ss       = ~SS_ON;
        in_valid = 1'b0;
        in_data  = 8'h00;
        exp_err  = 8'h00;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_wr_en",      32'(wr_en),      32'h0);
        chk("reset_wr_addr",    32'(wr_addr),    32'h0);
        chk("reset_wr_data",    32'(wr_data),    32'h0);
        chk("reset_swap",       32'(swap),       32'h0);
        chk("reset_err_count",  32'(err_count),  32'h0);
        chk("reset_brightness", 32'(brightness), 32'h80);
        prev_bright = brightness;
        prev_err    = err_count;
        mon_en      = 1'b1;
        repeat (3) @(negedge clk);

        // Write burst 01,00,05,AA,BB,CC.
        fb[0] = 8'h01; fb[1] = 8'h00; fb[2] = 8'h05;
        fb[3] = 8'hAA; fb[4] = 8'hBB; fb[5] = 8'hCC;
        push_ev(K_WR, 10'h005, 8'hAA, 3);
        push_ev(K_WR, 10'h006, 8'hBB, 4);
        push_ev(K_WR, 10'h007, 8'hCC, 5);
        run_frame(6, 1'b0);

        // Address wrap at 0x3FF.
        fb[0] = 8'h01; fb[1] = 8'h03; fb[2] = 8'hFF; fb[3] = 8'h11; fb[4] = 8'h22;
        push_ev(K_WR, 10'h3FF, 8'h11, 3);
        push_ev(K_WR, 10'h000, 8'h22, 4);
        run_frame(5, 1'b0);

        // Brightness 0x40; trailing 0x99 ignored.
        fb[0] = 8'h02; fb[1] = 8'h40; fb[2] = 8'h99;
        push_ev(K_BRI, '0, 8'h40, 1);
        run_frame(3, 1'b0);

        // Aborted write frame: nothing.
        fb[0] = 8'h01; fb[1] = 8'h00;
        run_frame(2, 1'b0);

        // Single swap pulse.
        fb[0] = 8'h03;
        push_ev(K_SWAP, '0, 8'h00, 0);
        run_frame(1, 1'b0);

        // Frame ends in DATA with no data; next frame's 05 is a bad command.
        fb[0] = 8'h01; fb[1] = 8'h00; fb[2] = 8'h02;
        run_frame(3, 1'b0);
        fb[0] = 8'h05;
        exp_err = 8'h01;
        push_ev(K_ERR, '0, 8'h01, 0);
        run_frame(1, 1'b0);

        // Last byte arrives in the same cycle SS goes inactive: still written.
        fb[0] = 8'h01; fb[1] = 8'h00; fb[2] = 8'h10; fb[3] = 8'hDD;
        push_ev(K_WR, 10'h010, 8'hDD, 3);
        run_frame(4, 1'b1);

        // 300 unknown commands: counter climbs to 255 then holds.
        fb[0] = 8'h7E;
        for (int k = 0; k < 300; k++) begin
            if (exp_err != 8'hFF) begin
                exp_err = exp_err + 8'h01;
                push_ev(K_ERR, '0, exp_err, 0);
            end
            run_frame(1, 1'b0);
        end
        chk("err_saturated", 32'(err_count), 32'hFF);

        // Reset pulse in the middle of a write burst.
        @(negedge clk);
        ss = SS_ON;
        repeat (2) @(negedge clk);
        fb[0] = 8'h01; fb[1] = 8'h00; fb[2] = 8'h20; fb[3] = 8'h31; fb[4] = 8'h32;
        push_ev(K_WR, 10'h020, 8'h31, 3);
        push_ev(K_WR, 10'h021, 8'h32, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) frame_base = cyc;
            in_valid = 1'b1;
            in_data  = fb[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        push_ev(K_BRI, '0, 8'h80, 0);
        push_ev(K_ERR, '0, 8'h00, 0);
        frame_base = cyc;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midreset_wr_addr", 32'(wr_addr), 32'h0);
        chk("midreset_wr_data", 32'(wr_data), 32'h0);
        fb[0] = 8'h41; fb[1] = 8'h42; fb[2] = 8'h43; fb[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = fb[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        ss       = ~SS_ON;
        repeat (5) @(negedge clk);

        // Next frame decodes normally.
        fb[0] = 8'h01; fb[1] = 8'h00; fb[2] = 8'h07; fb[3] = 8'h55;
        push_ev(K_WR, 10'h007, 8'h55, 3);
        run_frame(4, 1'b0);

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
- Consumes the byte stream (data/valid) produced by the SPI slave receiver in the display controller.
- Decodes framed commands, one command per SS assertion, into framebuffer write strobes, a brightness register and a buffer-swap pulse.
- Sits between the SPI slave and the display framebuffer/driver.

Parameters:
- ss_active, 1, SS level that marks an active frame; must match the SPI slave setting.
- ADDR_WIDTH, 10, framebuffer address width in bits; maximum 16.
- BRIGHT_RST, 8'h80, reset value of the brightness register.

Ports:
- clk  input  1  system clock; the only clock.
- rst  input  1  synchronous reset, active-low; takes effect on the clk rising edge while rst==0.
- ss  input  1  raw SPI slave-select from the pin (asynchronous to clk).
- in_data  input  8  received byte from the SPI slave.
- in_valid  input  1  one-cycle strobe; in_data is valid in the same cycle.
- wr_en  output  1  framebuffer write strobe, one cycle per byte.
- wr_addr  output  ADDR_WIDTH  framebuffer write address.
- wr_data  output  8  framebuffer write data.
- brightness  output  8  display brightness register.
- swap  output  1  one-cycle pulse requesting a front/back buffer swap.
- err_count  output  8  saturating count of unknown command bytes.

Behaviour:
- Reset while rst==0:
  - state=IDLE.
  - wr_en=0, wr_addr=0, wr_data=0, swap=0, err_count=0.
  - brightness=BRIGHT_RST; the address pointer is cleared.
  - Reset mid-frame discards the frame. Bytes in the rest of that frame are ignored: state stays DISCARD until SS goes inactive.
- SS is passed through a 2-flop synchronizer (ss_s). "Frame inactive" means ss_s != ss_active.
- Command byte decode, taken from the first in_valid in IDLE:
  - 0x00 NOP: go to DISCARD.
  - 0x01 WRITE: go to ADDR_HI.
  - 0x02 BRIGHT: go to BRIGHT.
  - 0x03 SWAP: swap=1 in the next cycle, then go to DISCARD.
  - Any other value: err_count += 1 (saturates at 255), then go to DISCARD.
- States and transitions, each on in_valid:
  - IDLE: decode the command as above.
  - ADDR_HI: ptr[high bits] = in_data; go to ADDR_LO. ptr = {hi,lo}, truncated to ADDR_WIDTH bits.
  - ADDR_LO: ptr[7:0] = in_data; go to DATA.
  - DATA:
    - wr_en=1, wr_addr=ptr, wr_data=in_data, all registered one cycle after in_valid.
    - Then ptr = ptr+1, wrapping from 2^ADDR_WIDTH-1 to 0. State stays DATA.
  - BRIGHT: brightness = in_data, applied in the next cycle; go to DISCARD.
  - DISCARD: ignore all bytes.
- Frame end: in any state, frame inactive forces the next state to IDLE.
  - If in_valid and frame inactive occur in the same cycle, the byte is still fully processed (write, brightness, swap, err) and the next state is IDLE.
  - A frame that ends in ADDR_HI or ADDR_LO writes nothing.
- Bytes arriving in IDLE while the frame is inactive are ignored.
- Latency: every output reacts exactly 1 clk after the triggering in_valid.
  - wr_en and swap are never high for two consecutive cycles from a single byte.
  - Back-to-back in_valid on consecutive cycles must be supported: a write every cycle.
- brightness holds its value across frames and changes only on BRIGHT or reset.

Decomposition:
- Shared package spi_cmd_pkg:
  - command codes CMD_NOP=8'h00, CMD_WRITE=8'h01, CMD_BRIGHT=8'h02, CMD_SWAP=8'h03.
  - state encoding: IDLE, ADDR_HI, ADDR_LO, DATA, BRIGHT, DISCARD.
- One sub-module, sync_2ff: a 1-bit two-flop synchronizer for ss, reset to !ss_active. It is reusable for other pin inputs.

Test Plan:
- Write burst: SS active; bytes 01,00,05,AA,BB,CC; SS inactive.
  - Expect wr_en pulses with (addr,data) = (5,AA),(6,BB),(7,CC), each 1 cycle after its in_valid.
- Wrap: WRITE at address 0x03FF (ADDR_WIDTH=10) with data 11,22.
  - Expect writes (0x3FF,11) then (0x000,22).
- Brightness: frame 02,40,99.
  - Expect brightness=0x40 one cycle after the second byte; 0x99 is ignored.
  - A following frame 01,00 aborted early produces no wr_en, and brightness stays 0x40.
- Swap and unknown commands:
  - Frame 03 gives exactly one swap pulse.
  - 300 frames each containing 7E give err_count saturated at 255, with no wr_en and no swap.
- Frame boundary: frame 01,00,02 ends; next frame 05,...
  - 05 is treated as a command (unknown), so err_count += 1 and there are no writes.
  - The last byte coinciding with SS deassert is still written.
- Reset mid-frame: rst=0 for 1 cycle during a DATA burst.
  - Outputs return to reset values and brightness=0x80.
  - Remaining bytes in that frame cause no writes; the next frame decodes normally.
